csr_regfile: RTL and testbench
==============================

Name: csr_regfile

Overview:
- Machine-mode CSR register file for the rv64 core.
- Sits between the EXU CSR instructions (csrrw/csrrs/csrrc) and the core local interruptor (CLINT).
- Receives trap/mret CSR writes from the CLINT and returns to it the interrupt-enable, pending, mtvec, mepc and mstatus values.
- Also maintains the mcycle/minstret counters and the live mip.MTIP view of the timer line.

Parameters:
- MSTATUS_RST, 64'h0000_0000_0000_1800, mstatus reset value (MPP=11).
- XLEN, 64, data width (fixed; not for override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- csr_op_i  in  2  00 none, 01 RW, 10 RS, 11 RC
- csr_addr_i  in  12  CSR address for read and instruction write
- csr_src_i  in  64  rs1 value or zimm zero-extended
- csr_src_zero_i  in  1  rs1=x0 / zimm=0 (suppresses RS/RC write)
- csr_rdata_o  out  64  old CSR value (combinational)
- csr_illegal_o  out  1  csr_op_i!=0 and address unimplemented
- instr_retire_i  in  1  one instruction retired this cycle
- timer_int_i  in  1  timer compare line
- clint_csr_wen_i  in  1  CLINT write enable
- clint_csr_waddr_i  in  12  CLINT write address
- clint_csr_wdata_i  in  64  CLINT write data
- global_int_en_o  out  1  mstatus.MIE
- mtime_int_en_o  out  1  mie.MTIE
- mtime_int_pend_o  out  1  mip.MTIP
- csr_mtvec_o  out  64  mtvec
- csr_mepc_o  out  64  mepc
- csr_mstatus_o  out  64  mstatus (SD computed)

Behaviour:
- Implemented CSRs (addr: reset value):
  - mstatus 0x300: MSTATUS_RST
  - mie 0x304: 0
  - mtvec 0x305: 0
  - mscratch 0x340: 0
  - mepc 0x341: 0
  - mcause 0x342: 0
  - mip 0x344: 0
  - mcycle 0xB00: 0
  - minstret 0xB02: 0
- Reset: all registers take the reset values above on any clk edge with rst=1, including mid-operation. All write inputs and counter increments are ignored that cycle.
- Read: csr_rdata_o = current register value, zero-latency combinational. Unimplemented address reads 0 and csr_illegal_o=1 when op!=0; no write occurs.
- Instruction write value:
  - RW: src.
  - RS: old|src.
  - RC: old&~src.
  - Write is suppressed for RS/RC when csr_src_zero_i=1.
  - Takes effect at the next clk edge; the old value is returned the same cycle.
- Field masks, applied to both write ports:
  - mstatus: writable bits 3 (MIE), 7 (MPIE), 12:11 (MPP), 14:13 (FS), 16:15 (XS). Other bits hold.
  - mstatus bit63 SD is not stored; it reads as (FS==2'b11)|(XS==2'b11).
  - mtvec: bits 1:0 forced 0 (direct mode only).
  - mepc: bit 0 forced 0.
  - mie: only bit 7 writable.
  - mip: no stored writable bits. Bit 7 reads as the registered timer_int_i (1-cycle latency); all other bits read 0.
- Counters:
  - mcycle increments by 1 every cycle; minstret increments when instr_retire_i=1. Both wrap 2^64-1 -> 0.
  - An explicit write in the same cycle wins over the increment (value written, no +1).
- Write port collision: if both ports write in the same cycle to different addresses, both apply. On the same address, the CLINT write wins and the instruction write is dropped.
- CLINT port has no handshake: accepted unconditionally every cycle wen=1. A CLINT write to an unimplemented or read-only address is ignored.
- Output ports reflect register state after the edge. A CLINT mstatus write clearing MIE drives global_int_en_o=0 in the next cycle.

Decomposition:
- Shared defines header: CSR addresses (ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC, ADDR_MCAUSE, ADDR_MIP, ADDR_MCYCLE, ADDR_MINSTRET), csr_op encodings, mstatus bit positions and writable masks.
- One natural sub-module: csr_counter (64-bit wrap counter with increment enable and load port), instantiated for mcycle and minstret.

Test Plan:
- Reset: assert rst for 2 cycles mid-count -> mstatus=0x1800, mcycle=0, all outputs 0 except csr_mstatus_o=0x1800.
- CSRRS mstatus src=0x8, then CSRRC mie src=0 with src_zero=1 -> global_int_en_o=1 next cycle; rdata returns 0x1800 first; mie write suppressed.
- Same-cycle writes: instruction RW mepc=0x1111 and CLINT mepc=0x8000_0004 -> mepc=0x8000_0004. Then instruction mtvec=0x8000_0103 with CLINT mcause=0x8000_0000_0000_0007 -> mtvec=0x8000_0100 and mcause set.
- Counters: RW mcycle=0xFFFF_FFFF_FFFF_FFFE, then idle 3 cycles -> reads ...FFFE, ...FFFF, 0. minstret counts only cycles with instr_retire_i=1 (pulse 5 of 8 -> 5).
- MTIP: timer_int_i 0->1 -> mtime_int_pend_o=1 one cycle later. RW mip=0 ignored; illegal address 0x7C0 -> rdata 0, csr_illegal_o=1.
- FS/XS: write FS=11 -> csr_mstatus_o[63]=1. Write FS=00, XS=00 -> bit63=0.

Source files
------------

// File: rtl/csr_regfile_pkg.sv
// Shared definitions for the machine-mode CSR register file: addresses, op
// encodings, mstatus field positions, write masks and small helpers.
package csr_regfile_pkg;

    localparam int XLEN = 64;
    localparam logic [63:0] MSTATUS_RST_DEFAULT = 64'h0000_0000_0000_1800;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_FS_LO    = 13;
    localparam int MSTATUS_XS_LO    = 15;
    localparam int MSTATUS_SD_BIT   = 63;
    localparam int MIE_MTIE_BIT     = 7;

    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0001_F888;
    localparam logic [63:0] MIE_WMASK     = 64'h0000_0000_0000_0080;
    localparam logic [63:0] MTVEC_WMASK   = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] MEPC_WMASK    = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] FULL_WMASK    = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic csr_implemented(input logic [11:0] addr);
        case (addr)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
            ADDR_MCAUSE, ADDR_MIP, ADDR_MCYCLE, ADDR_MINSTRET: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] csr_merge(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [63:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    function automatic logic mstatus_sd(input logic [63:0] mstatus);
        return (mstatus[MSTATUS_FS_LO+1:MSTATUS_FS_LO] == 2'b11) ||
               (mstatus[MSTATUS_XS_LO+1:MSTATUS_XS_LO] == 2'b11);
    endfunction

endpackage

// File: rtl/csr_regfile_counter.sv
// 64-bit wrapping counter with increment enable; a load in the same cycle
// takes priority over the increment.
module csr_counter
    import csr_regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_val_i,
    output logic [XLEN-1:0] count_o
);

    logic [XLEN-1:0] count_d;
    logic [XLEN-1:0] count_q;

    // next count: load beats increment
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + 64'd1;
        end else begin
            count_d = count_q;
        end
    end

    // counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 64'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: instruction read/modify/write port, CLINT
// trap write port, mcycle/minstret counters and the mip.MTIP timer view.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [63:0] MSTATUS_RST = MSTATUS_RST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_src_i,
    input  logic            csr_src_zero_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            instr_retire_i,
    input  logic            timer_int_i,
    input  logic            clint_csr_wen_i,
    input  logic [11:0]     clint_csr_waddr_i,
    input  logic [XLEN-1:0] clint_csr_wdata_i,
    output logic            global_int_en_o,
    output logic            mtime_int_en_o,
    output logic            mtime_int_pend_o,
    output logic [XLEN-1:0] csr_mtvec_o,
    output logic [XLEN-1:0] csr_mepc_o,
    output logic [XLEN-1:0] csr_mstatus_o
);

    logic [XLEN-1:0] mstatus_d, mstatus_q;
    logic [XLEN-1:0] mie_d, mie_q;
    logic [XLEN-1:0] mtvec_d, mtvec_q;
    logic [XLEN-1:0] mscratch_d, mscratch_q;
    logic [XLEN-1:0] mepc_d, mepc_q;
    logic [XLEN-1:0] mcause_d, mcause_q;
    logic            mtip_d, mtip_q;
    logic [XLEN-1:0] mcycle_s, minstret_s;
    logic [XLEN-1:0] mstatus_rd_s;
    logic [XLEN-1:0] instr_wdata_s;
    logic            instr_wreq_s;
    logic            instr_we_s;

    // SD is never stored; bit 63 of mstatus_q stays 0 so OR-ing it in is exact
    assign mstatus_rd_s = mstatus_q | {mstatus_sd(mstatus_q), 63'd0};

    // instruction-port read mux
    always_comb begin
        csr_rdata_o = 64'd0;
        case (csr_addr_i)
            ADDR_MSTATUS:  csr_rdata_o = mstatus_rd_s;
            ADDR_MIE:      csr_rdata_o = mie_q;
            ADDR_MTVEC:    csr_rdata_o = mtvec_q;
            ADDR_MSCRATCH: csr_rdata_o = mscratch_q;
            ADDR_MEPC:     csr_rdata_o = mepc_q;
            ADDR_MCAUSE:   csr_rdata_o = mcause_q;
            ADDR_MIP:      csr_rdata_o = {56'd0, mtip_q, 7'd0};
            ADDR_MCYCLE:   csr_rdata_o = mcycle_s;
            ADDR_MINSTRET: csr_rdata_o = minstret_s;
            default:       csr_rdata_o = 64'd0;
        endcase
    end

    assign csr_illegal_o = (csr_op_i != CSR_OP_NONE) && !csr_implemented(csr_addr_i);

    // instruction write value; RS/RC with a zero source is a pure read
    always_comb begin
        instr_wdata_s = csr_src_i;
        instr_wreq_s  = 1'b0;
        case (csr_op_i)
            CSR_OP_RW: begin
                instr_wdata_s = csr_src_i;
                instr_wreq_s  = 1'b1;
            end
            CSR_OP_RS: begin
                instr_wdata_s = csr_rdata_o | csr_src_i;
                instr_wreq_s  = !csr_src_zero_i;
            end
            CSR_OP_RC: begin
                instr_wdata_s = csr_rdata_o & ~csr_src_i;
                instr_wreq_s  = !csr_src_zero_i;
            end
            default: begin
                instr_wdata_s = csr_src_i;
                instr_wreq_s  = 1'b0;
            end
        endcase
    end

    // CLINT owns the address on a same-address collision
    assign instr_we_s = instr_wreq_s && csr_implemented(csr_addr_i) &&
                        !(clint_csr_wen_i && (clint_csr_waddr_i == csr_addr_i));

    function automatic logic [XLEN-1:0] next_val(input logic [XLEN-1:0] old_val,
                                                 input logic [11:0]     addr,
                                                 input logic [XLEN-1:0] mask,
                                                 input logic            c_wen,
                                                 input logic [11:0]     c_addr,
                                                 input logic [XLEN-1:0] c_data,
                                                 input logic            i_wen,
                                                 input logic [11:0]     i_addr,
                                                 input logic [XLEN-1:0] i_data);
        if (c_wen && (c_addr == addr)) begin
            return csr_merge(old_val, c_data, mask);
        end else if (i_wen && (i_addr == addr)) begin
            return csr_merge(old_val, i_data, mask);
        end else begin
            return old_val;
        end
    endfunction

    // next state of the stored CSRs
    always_comb begin
        mstatus_d  = next_val(mstatus_q, ADDR_MSTATUS, MSTATUS_WMASK, clint_csr_wen_i,
                              clint_csr_waddr_i, clint_csr_wdata_i, instr_we_s, csr_addr_i, instr_wdata_s);
        mie_d      = next_val(mie_q, ADDR_MIE, MIE_WMASK, clint_csr_wen_i,
                              clint_csr_waddr_i, clint_csr_wdata_i, instr_we_s, csr_addr_i, instr_wdata_s);
        mtvec_d    = next_val(mtvec_q, ADDR_MTVEC, MTVEC_WMASK, clint_csr_wen_i,
                              clint_csr_waddr_i, clint_csr_wdata_i, instr_we_s, csr_addr_i, instr_wdata_s);
        mscratch_d = next_val(mscratch_q, ADDR_MSCRATCH, FULL_WMASK, clint_csr_wen_i,
                              clint_csr_waddr_i, clint_csr_wdata_i, instr_we_s, csr_addr_i, instr_wdata_s);
        mepc_d     = next_val(mepc_q, ADDR_MEPC, MEPC_WMASK, clint_csr_wen_i,
                              clint_csr_waddr_i, clint_csr_wdata_i, instr_we_s, csr_addr_i, instr_wdata_s);
        mcause_d   = next_val(mcause_q, ADDR_MCAUSE, FULL_WMASK, clint_csr_wen_i,
                              clint_csr_waddr_i, clint_csr_wdata_i, instr_we_s, csr_addr_i, instr_wdata_s);
        mtip_d     = timer_int_i;
    end

    // CSR state
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_RST;
            mie_q      <= 64'd0;
            mtvec_q    <= 64'd0;
            mscratch_q <= 64'd0;
            mepc_q     <= 64'd0;
            mcause_q   <= 64'd0;
            mtip_q     <= 1'b0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtip_q     <= mtip_d;
        end
    end

    csr_counter u_mcycle (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (1'b1),
        .load_i     ((clint_csr_wen_i && (clint_csr_waddr_i == ADDR_MCYCLE)) ||
                     (instr_we_s && (csr_addr_i == ADDR_MCYCLE))),
        .load_val_i ((clint_csr_wen_i && (clint_csr_waddr_i == ADDR_MCYCLE)) ?
                     clint_csr_wdata_i : instr_wdata_s),
        .count_o    (mcycle_s)
    );

    csr_counter u_minstret (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (instr_retire_i),
        .load_i     ((clint_csr_wen_i && (clint_csr_waddr_i == ADDR_MINSTRET)) ||
                     (instr_we_s && (csr_addr_i == ADDR_MINSTRET))),
        .load_val_i ((clint_csr_wen_i && (clint_csr_waddr_i == ADDR_MINSTRET)) ?
                     clint_csr_wdata_i : instr_wdata_s),
        .count_o    (minstret_s)
    );

    assign global_int_en_o  = mstatus_q[MSTATUS_MIE_BIT];
    assign mtime_int_en_o   = mie_q[MIE_MTIE_BIT];
    assign mtime_int_pend_o = mtip_q;
    assign csr_mtvec_o      = mtvec_q;
    assign csr_mepc_o       = mepc_q;
    assign csr_mstatus_o    = mstatus_rd_s;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: table of instruction-port vectors plus
// hand-written reset, collision, counter and timer sequences, via a scoreboard.
module tb_csr_regfile;

    logic        clk;
    logic        rst;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [63:0] csr_src_i;
    logic        csr_src_zero_i;
    logic [63:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        instr_retire_i;
    logic        timer_int_i;
    logic        clint_csr_wen_i;
    logic [11:0] clint_csr_waddr_i;
    logic [63:0] clint_csr_wdata_i;
    logic        global_int_en_o;
    logic        mtime_int_en_o;
    logic        mtime_int_pend_o;
    logic [63:0] csr_mtvec_o;
    logic [63:0] csr_mepc_o;
    logic [63:0] csr_mstatus_o;

    csr_regfile dut (
        .clk               (clk),
        .rst               (rst),
        .csr_op_i          (csr_op_i),
        .csr_addr_i        (csr_addr_i),
        .csr_src_i         (csr_src_i),
        .csr_src_zero_i    (csr_src_zero_i),
        .csr_rdata_o       (csr_rdata_o),
        .csr_illegal_o     (csr_illegal_o),
        .instr_retire_i    (instr_retire_i),
        .timer_int_i       (timer_int_i),
        .clint_csr_wen_i   (clint_csr_wen_i),
        .clint_csr_waddr_i (clint_csr_waddr_i),
        .clint_csr_wdata_i (clint_csr_wdata_i),
        .global_int_en_o   (global_int_en_o),
        .mtime_int_en_o    (mtime_int_en_o),
        .mtime_int_pend_o  (mtime_int_pend_o),
        .csr_mtvec_o       (csr_mtvec_o),
        .csr_mepc_o        (csr_mepc_o),
        .csr_mstatus_o     (csr_mstatus_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_RDATA = 0, S_ILL = 1, S_GIE = 2, S_MTIE = 3, S_MTIP = 4,
                   S_MTVEC = 5, S_MEPC = 6, S_MSTATUS = 7;

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [63:0] src;
        logic        zero;
        logic [63:0] exp_rdata;
        logic        exp_ill;
        logic        exp_gie;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[21];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [63:0] dut_out(input int sel);
        case (sel)
            S_RDATA:   return csr_rdata_o;
            S_ILL:     return {63'd0, csr_illegal_o};
            S_GIE:     return {63'd0, global_int_en_o};
            S_MTIE:    return {63'd0, mtime_int_en_o};
            S_MTIP:    return {63'd0, mtime_int_pend_o};
            S_MTVEC:   return csr_mtvec_o;
            S_MEPC:    return csr_mepc_o;
            S_MSTATUS: return csr_mstatus_o;
            default:   return 64'd0;
        endcase
    endfunction

    task automatic expect_out(input string name, input int sel, input logic [63:0] exp);
        exp_t e;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        logic [63:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = dut_out(e.sel);
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic settle_check();
        #1;
        check_sb();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        csr_op_i          = 2'b00;
        csr_addr_i        = 12'h000;
        csr_src_i         = 64'd0;
        csr_src_zero_i    = 1'b0;
        instr_retire_i    = 1'b0;
        clint_csr_wen_i   = 1'b0;
        clint_csr_waddr_i = 12'h000;
        clint_csr_wdata_i = 64'd0;
    endtask

    task automatic instr(input logic [1:0] op, input logic [11:0] addr,
                         input logic [63:0] src, input logic zero);
        csr_op_i       = op;
        csr_addr_i     = addr;
        csr_src_i      = src;
        csr_src_zero_i = zero;
    endtask

    task automatic clint(input logic wen, input logic [11:0] addr, input logic [63:0] data);
        clint_csr_wen_i   = wen;
        clint_csr_waddr_i = addr;
        clint_csr_wdata_i = data;
    endtask

    logic [63:0] cyc_exp[3];
    logic [7:0]  retire_pat;

    initial begin
        // instruction-port vectors, applied back to back from reset state
        vecs[0]  = '{2'b10, 12'h300, 64'h8,                   1'b0, 64'h1800,                1'b0, 1'b0};
        vecs[1]  = '{2'b11, 12'h304, 64'h0,                   1'b1, 64'h0,                   1'b0, 1'b1};
        vecs[2]  = '{2'b00, 12'h300, 64'h0,                   1'b0, 64'h1808,                1'b0, 1'b1};
        vecs[3]  = '{2'b01, 12'h304, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0,                   1'b0, 1'b1};
        vecs[4]  = '{2'b00, 12'h304, 64'h0,                   1'b0, 64'h80,                  1'b0, 1'b1};
        vecs[5]  = '{2'b01, 12'h305, 64'h8000_0103,           1'b0, 64'h0,                   1'b0, 1'b1};
        vecs[6]  = '{2'b00, 12'h305, 64'h0,                   1'b0, 64'h8000_0100,           1'b0, 1'b1};
        vecs[7]  = '{2'b01, 12'h341, 64'h13,                  1'b0, 64'h0,                   1'b0, 1'b1};
        vecs[8]  = '{2'b11, 12'h341, 64'h2,                   1'b0, 64'h12,                  1'b0, 1'b1};
        vecs[9]  = '{2'b00, 12'h341, 64'h0,                   1'b0, 64'h10,                  1'b0, 1'b1};
        vecs[10] = '{2'b01, 12'h344, 64'h0,                   1'b0, 64'h0,                   1'b0, 1'b1};
        vecs[11] = '{2'b01, 12'h7C0, 64'h5,                   1'b0, 64'h0,                   1'b1, 1'b1};
        vecs[12] = '{2'b00, 12'h7C0, 64'h0,                   1'b0, 64'h0,                   1'b0, 1'b1};
        vecs[13] = '{2'b01, 12'h340, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'h0,                   1'b0, 1'b1};
        vecs[14] = '{2'b10, 12'h340, 64'h0,                   1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1};
        vecs[15] = '{2'b11, 12'h340, 64'hFFFF_0000_0000_0000, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1};
        vecs[16] = '{2'b00, 12'h340, 64'h0,                   1'b0, 64'h0000_BEEF_CAFE_F00D, 1'b0, 1'b1};
        vecs[17] = '{2'b01, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h1808,                1'b0, 1'b1};
        vecs[18] = '{2'b00, 12'h300, 64'h0,                   1'b0, 64'h8000_0000_0001_F888, 1'b0, 1'b1};
        vecs[19] = '{2'b11, 12'h300, 64'h1_E000,              1'b0, 64'h8000_0000_0001_F888, 1'b0, 1'b1};
        vecs[20] = '{2'b00, 12'h300, 64'h0,                   1'b0, 64'h1888,                1'b0, 1'b1};

        idle_inputs();
        timer_int_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // make state non-trivial, then reset mid-count with writes pending
        clint(1'b1, 12'h341, 64'h40);
        instr(2'b01, 12'h304, 64'h80, 1'b0);
        timer_int_i = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
        clint(1'b1, 12'h341, 64'h123);
        instr(2'b01, 12'h305, 64'h500, 1'b0);
        instr_retire_i = 1'b1;
        tick();
        tick();
        idle_inputs();
        csr_addr_i = 12'hB00;
        expect_out("rst_mcycle",  S_RDATA,   64'd0);
        expect_out("rst_mstatus", S_MSTATUS, 64'h1800);
        expect_out("rst_gie",     S_GIE,     64'd0);
        expect_out("rst_mtie",    S_MTIE,    64'd0);
        expect_out("rst_mtip",    S_MTIP,    64'd0);
        expect_out("rst_mtvec",   S_MTVEC,   64'd0);
        expect_out("rst_mepc",    S_MEPC,    64'd0);
        settle_check();
        csr_addr_i = 12'hB02;
        expect_out("rst_minstret", S_RDATA, 64'd0);
        settle_check();
        rst = 1'b0;
        timer_int_i = 1'b0;
        tick();

        for (int i = 0; i < 21; i++) begin
            instr(vecs[i].op, vecs[i].addr, vecs[i].src, vecs[i].zero);
            expect_out($sformatf("vec%0d_rdata", i), S_RDATA, vecs[i].exp_rdata);
            expect_out($sformatf("vec%0d_ill", i),   S_ILL,   {63'd0, vecs[i].exp_ill});
            expect_out($sformatf("vec%0d_gie", i),   S_GIE,   {63'd0, vecs[i].exp_gie});
            settle_check();
            tick();
        end
        idle_inputs();
        expect_out("mtie_set", S_MTIE, 64'd1);
        settle_check();

        // same-address collision: CLINT wins
        instr(2'b01, 12'h341, 64'h1111, 1'b0);
        clint(1'b1, 12'h341, 64'h8000_0004);
        tick();
        expect_out("coll_mepc", S_MEPC, 64'h8000_0004);
        check_sb();

        // different addresses: both land
        instr(2'b01, 12'h305, 64'h8000_0103, 1'b0);
        clint(1'b1, 12'h342, 64'h8000_0000_0000_0007);
        tick();
        idle_inputs();
        csr_addr_i = 12'h342;
        expect_out("dual_mtvec",  S_MTVEC, 64'h8000_0100);
        expect_out("dual_mcause", S_RDATA, 64'h8000_0000_0000_0007);
        settle_check();

        // CLINT clears MIE while the instruction tries to set it
        instr(2'b10, 12'h300, 64'h8, 1'b0);
        clint(1'b1, 12'h300, 64'h0);
        expect_out("gie_before", S_GIE, 64'd1);
        settle_check();
        tick();
        idle_inputs();
        expect_out("gie_cleared",  S_GIE,     64'd0);
        expect_out("mstatus_zero", S_MSTATUS, 64'd0);
        settle_check();

        // mcycle load beats increment, then wraps
        instr(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        tick();
        idle_inputs();
        csr_addr_i = 12'hB00;
        cyc_exp[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        cyc_exp[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc_exp[2] = 64'h0;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("mcycle_wrap%0d", i), S_RDATA, cyc_exp[i]);
            settle_check();
            tick();
        end

        // minstret counts only retiring cycles
        retire_pat = 8'b1010_1101;
        instr(2'b01, 12'hB02, 64'h0, 1'b0);
        tick();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            instr_retire_i = retire_pat[i];
            tick();
        end
        instr_retire_i = 1'b0;
        csr_addr_i = 12'hB02;
        expect_out("minstret_5", S_RDATA, 64'd5);
        settle_check();
        instr(2'b01, 12'hB02, 64'd100, 1'b0);
        instr_retire_i = 1'b1;
        tick();
        idle_inputs();
        csr_addr_i = 12'hB02;
        expect_out("minstret_load", S_RDATA, 64'd100);
        settle_check();

        // MTIP follows the timer line one cycle late; mip writes are ignored
        timer_int_i = 1'b1;
        expect_out("mtip_lag", S_MTIP, 64'd0);
        settle_check();
        tick();
        csr_addr_i = 12'h344;
        expect_out("mtip_set", S_MTIP,  64'd1);
        expect_out("mip_read", S_RDATA, 64'h80);
        settle_check();
        instr(2'b01, 12'h344, 64'h0, 1'b0);
        tick();
        idle_inputs();
        csr_addr_i = 12'h344;
        expect_out("mip_ro", S_RDATA, 64'h80);
        settle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
